tex_dcr_bank: RTL and testbench
===============================

Name: tex_dcr_bank

Overview:
- Multi-stage texture DCR register file. Holds one active `tex_dcrs_t` per texture stage (NUM_STAGES) and one shadow copy of each.
- The DCR write bus fills the shadow copy. A per-stage COMMIT write copies shadow to active, but only once no sampler request that uses the stage is still in flight.
- Texture units look up a stage through a one-deep registered request/response pipe. It sits between the DCR bus and the tex unit request front-end.

Parameters:
- NUM_STAGES, 4, number of texture stages (≥1).
- INFLIGHT_BITS, 4, width of the per-stage in-flight counter. Maximum count is 2^INFLIGHT_BITS−1.
- DATA_BITS, 32, DCR write data width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- dcr_wr_valid  in  1  DCR write strobe
- dcr_wr_ready  out  1  write accepted this cycle
- dcr_wr_stage  in  STAGE_BITS  target stage. STAGE_BITS = max(1, clog2(NUM_STAGES)).
- dcr_wr_offset  in  OFF_BITS  register offset. OFF_BITS = clog2(6+TEX_LOD_MAX+1).
- dcr_wr_data  in  DATA_BITS  write data
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted
- req_stage  in  STAGE_BITS  stage to look up
- rsp_valid  out  1  lookup result valid
- rsp_ready  in  1  consumer accepts result
- rsp_dcrs  out  $bits(tex_dcrs_t)  active state of the stage
- done_valid  in  1  a sampler request has retired
- done_stage  in  STAGE_BITS  stage of the retired request
- pending_commit  out  NUM_STAGES  per-stage commit-pending flags

Behaviour:
- Reset (asynchronous assert, synchronous release): all shadow/active fields 0, counters 0, pending 0. Outputs: rsp_valid=0, rsp_dcrs=0, dcr_wr_ready=1, req_ready=1.
- Offset map and field slicing:
  - 0 BASEADDR: data[TEX_ADDR_BITS-1:0].
  - 1 LOGDIM: u = data[TEX_LOD_BITS-1:0], v = data[16+:TEX_LOD_BITS].
  - 2 WRAP: u = data[1:0], v = data[17:16].
  - 3 FORMAT: data[2:0].
  - 4 FILTER: data[0].
  - 5 COMMIT: data ignored.
  - 6+k MIPOFF[k]: data[TEX_MIPOFF_BITS-1:0], for k = 0..TEX_LOD_MAX.
  - Unmapped offsets and stage ≥ NUM_STAGES: accepted, no effect.
- Write handshake: dcr_wr_ready = !pending[dcr_wr_stage] (combinational).
  - An accepted field write updates the shadow on the next edge.
  - An accepted COMMIT sets pending[stage].
  - A stalled writer must hold its inputs stable.
- Commit condition for stage s, all of which must hold in the same cycle:
  - pending[s]=1;
  - cnt[s]=0;
  - no request to s is accepted this cycle.
  - Effect: on that edge active[s] ← shadow[s] and pending[s] ← 0. The stage is writable again the next cycle.
- An accepted COMMIT to a stage with cnt=0 commits no earlier than the following cycle.
- Lookup:
  - req_ready = (!rsp_valid || rsp_ready) && cnt[req_stage] != max.
  - On acceptance: rsp_dcrs ← active[req_stage], rsp_valid ← 1, and cnt[req_stage] increments. Latency is 1 cycle.
  - Lookups always return active state, never shadow.
  - rsp_valid clears on rsp_ready when no new request is accepted.
  - rsp_dcrs is held stable while rsp_valid && !rsp_ready.
- done handling: done_valid decrements cnt[done_stage].
  - Increment and decrement on the same stage in the same cycle leave the count unchanged.
  - A decrement at 0 is a protocol error: assertion fires, count stays 0.
- pending_commit mirrors the pending register.
- A reset mid-commit discards shadow and pending state.

Decomposition:
- The tex types package gains:
  - `TEX_DCR_OFF_*` offset constants and the OFF_BITS/STAGE_BITS width macros;
  - a `tex_dcr_write_t` struct {stage, offset, data};
  - a `tex_dcrs_t` field-update function keyed by offset.
- One sub-module, `tex_dcr_stage`, instantiated NUM_STAGES times. It holds shadow, active, pending and cnt for one stage, and computes that stage's commit condition.

Test Plan:
- Field writes and commit: write stage 1 BASEADDR=0x0123_4567 and FORMAT=5, then COMMIT, lookup stage 1 → rsp_dcrs.baseaddr = 0x0123_4567 truncated to TEX_ADDR_BITS, format = 5.
- Shadow invisible before commit: after writing FILTER=1 to stage 0 without COMMIT, a lookup of stage 0 → filter = 0.
- Commit deferred by in-flight work:
  - accept 3 lookups on stage 2, then COMMIT → pending_commit[2]=1 and dcr_wr_ready=0 for stage 2;
  - after 3 done_valid on stage 2, active updates on the next edge and pending clears.
- Same-cycle inc/dec: with cnt=1, accept a lookup and a done on the same stage in one cycle → cnt stays 1 and commit does not fire.
- Backpressure and saturation:
  - hold rsp_ready=0 → rsp_dcrs is stable and req_ready=0;
  - with cnt at 15 (INFLIGHT_BITS=4) → req_ready=0 for that stage only.
- Reset mid-operation: assert reset_n=0 while pending and rsp_valid are 1 → all outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tex_dcr_bank_pkg.sv
// Texture DCR types, register offset map and the field-update helper shared by
// the DCR bank, its per-stage slice and its bus interface.
package tex_dcr_bank_pkg;

  localparam int TEX_ADDR_BITS   = 26;
  localparam int TEX_LOD_BITS    = 4;
  localparam int TEX_LOD_MAX     = 3;
  localparam int TEX_MIPOFF_BITS = 16;

  localparam int TEX_DCR_DATA_BITS      = 32;
  localparam int TEX_DCR_STAGE_BITS_MAX = 8;
  localparam int TEX_DCR_OFF_BITS       = $clog2(6 + TEX_LOD_MAX + 1);

  function automatic int tex_dcr_stage_bits(int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

  typedef logic [TEX_DCR_OFF_BITS-1:0] tex_dcr_off_t;

  localparam tex_dcr_off_t TEX_DCR_OFF_BASEADDR = tex_dcr_off_t'(0);
  localparam tex_dcr_off_t TEX_DCR_OFF_LOGDIM   = tex_dcr_off_t'(1);
  localparam tex_dcr_off_t TEX_DCR_OFF_WRAP     = tex_dcr_off_t'(2);
  localparam tex_dcr_off_t TEX_DCR_OFF_FORMAT   = tex_dcr_off_t'(3);
  localparam tex_dcr_off_t TEX_DCR_OFF_FILTER   = tex_dcr_off_t'(4);
  localparam tex_dcr_off_t TEX_DCR_OFF_COMMIT   = tex_dcr_off_t'(5);
  localparam tex_dcr_off_t TEX_DCR_OFF_MIPOFF0  = tex_dcr_off_t'(6);

  typedef struct packed {
    logic [TEX_ADDR_BITS-1:0]                        baseaddr;
    logic [TEX_LOD_BITS-1:0]                         logdim_u;
    logic [TEX_LOD_BITS-1:0]                         logdim_v;
    logic [1:0]                                      wrap_u;
    logic [1:0]                                      wrap_v;
    logic [2:0]                                      format;
    logic                                            filter;
    logic [TEX_LOD_MAX:0][TEX_MIPOFF_BITS-1:0]       mipoff;
  } tex_dcrs_t;

  typedef struct packed {
    logic [TEX_DCR_STAGE_BITS_MAX-1:0] stage;
    tex_dcr_off_t                      offset;
    logic [TEX_DCR_DATA_BITS-1:0]      data;
  } tex_dcr_write_t;

  // COMMIT and unmapped offsets leave the state untouched.
  function automatic tex_dcrs_t tex_dcr_update(tex_dcrs_t cur, tex_dcr_off_t off,
                                               logic [TEX_DCR_DATA_BITS-1:0] data);
    tex_dcrs_t nxt;
    nxt = cur;
    case (off)
      TEX_DCR_OFF_BASEADDR: nxt.baseaddr = data[TEX_ADDR_BITS-1:0];
      TEX_DCR_OFF_LOGDIM: begin
        nxt.logdim_u = data[TEX_LOD_BITS-1:0];
        nxt.logdim_v = data[16 +: TEX_LOD_BITS];
      end
      TEX_DCR_OFF_WRAP: begin
        nxt.wrap_u = data[1:0];
        nxt.wrap_v = data[17:16];
      end
      TEX_DCR_OFF_FORMAT: nxt.format = data[2:0];
      TEX_DCR_OFF_FILTER: nxt.filter = data[0];
      default: begin
        for (int unsigned k = 0; k <= TEX_LOD_MAX; k++) begin
          if (off == tex_dcr_off_t'(TEX_DCR_OFF_MIPOFF0 + k)) begin
            nxt.mipoff[k] = data[TEX_MIPOFF_BITS-1:0];
          end
        end
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tex_dcr_bank_if.sv
// DCR write bus, lookup request/response pipe and retire port of the texture
// DCR bank. The master side is the DCR writer / tex unit front-end.
interface tex_dcr_bank_if #(
  parameter int NUM_STAGES = 4,
  parameter int DATA_BITS  = 32
);
  import tex_dcr_bank_pkg::*;

  localparam int STAGE_BITS = tex_dcr_stage_bits(NUM_STAGES);

  logic                  dcr_wr_valid;
  logic                  dcr_wr_ready;
  logic [STAGE_BITS-1:0] dcr_wr_stage;
  tex_dcr_off_t          dcr_wr_offset;
  logic [DATA_BITS-1:0]  dcr_wr_data;

  logic                  req_valid;
  logic                  req_ready;
  logic [STAGE_BITS-1:0] req_stage;

  logic                  rsp_valid;
  logic                  rsp_ready;
  tex_dcrs_t             rsp_dcrs;

  logic                  done_valid;
  logic [STAGE_BITS-1:0] done_stage;

  modport master (
    output dcr_wr_valid, dcr_wr_stage, dcr_wr_offset, dcr_wr_data,
    input  dcr_wr_ready,
    output req_valid, req_stage,
    input  req_ready,
    input  rsp_valid, rsp_dcrs,
    output rsp_ready,
    output done_valid, done_stage
  );

  modport slave (
    input  dcr_wr_valid, dcr_wr_stage, dcr_wr_offset, dcr_wr_data,
    output dcr_wr_ready,
    input  req_valid, req_stage,
    output req_ready,
    output rsp_valid, rsp_dcrs,
    input  rsp_ready,
    input  done_valid, done_stage
  );

endinterface

// File: rtl/tex_dcr_bank_stage.sv
// One texture stage: shadow and active DCR copies, commit-pending flag and the
// in-flight sampler request counter that gates the shadow->active copy.
module tex_dcr_stage
  import tex_dcr_bank_pkg::*;
#(
  parameter int INFLIGHT_BITS = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en_i,
  input  tex_dcr_off_t                 wr_off_i,
  input  logic [TEX_DCR_DATA_BITS-1:0] wr_data_i,
  input  logic                         req_acc_i,
  input  logic                         done_i,
  output tex_dcrs_t                    active_o,
  output logic                         pending_o,
  output logic                         full_o
);

  tex_dcrs_t                shadow_q, shadow_d;
  tex_dcrs_t                active_q, active_d;
  logic                     pending_q, pending_d;
  logic [INFLIGHT_BITS-1:0] cnt_q, cnt_d;
  logic                     commit;

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;

    // A lookup accepted this cycle still reads the old active copy, so it
    // holds the commit off for one more cycle.
    commit = pending_q && (cnt_q == '0) && !req_acc_i;
    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    // Writes are only accepted while not pending, so they never race a commit.
    if (wr_en_i) begin
      if (wr_off_i == TEX_DCR_OFF_COMMIT) begin
        pending_d = 1'b1;
      end else begin
        shadow_d = tex_dcr_update(shadow_q, wr_off_i, wr_data_i);
      end
    end

    if (req_acc_i && !done_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (done_i && !req_acc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign active_o  = active_q;
  assign pending_o = pending_q;
  assign full_o    = (cnt_q == '1);

  a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n)
    !(done_i && !req_acc_i && (cnt_q == '0)));

endmodule

// File: rtl/tex_dcr_bank.sv
// Multi-stage texture DCR register file: shadow fill over the DCR bus, deferred
// commit to active state, and a one-deep registered lookup pipe.
module tex_dcr_bank
  import tex_dcr_bank_pkg::*;
#(
  parameter int NUM_STAGES    = 4,
  parameter int INFLIGHT_BITS = 4,
  parameter int DATA_BITS     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tex_dcr_bank_if.slave         bus,
  output logic [NUM_STAGES-1:0] pending_commit
);

  localparam int STAGE_BITS = tex_dcr_stage_bits(NUM_STAGES);

  tex_dcr_write_t        wr;
  tex_dcrs_t             active [NUM_STAGES];
  logic [NUM_STAGES-1:0] pending;
  logic [NUM_STAGES-1:0] full;
  logic [NUM_STAGES-1:0] wr_sel;
  logic [NUM_STAGES-1:0] req_sel;
  logic [NUM_STAGES-1:0] done_sel;

  logic      wr_ready, req_ready, sel_full;
  logic      wr_fire, req_fire;
  tex_dcrs_t sel_active;

  logic      rsp_valid_q, rsp_valid_d;
  tex_dcrs_t rsp_dcrs_q, rsp_dcrs_d;

  always_comb begin
    wr.stage  = TEX_DCR_STAGE_BITS_MAX'(bus.dcr_wr_stage);
    wr.offset = bus.dcr_wr_offset;
    wr.data   = TEX_DCR_DATA_BITS'(bus.dcr_wr_data);
  end

  // Stage decode; out-of-range stages match nothing and are accepted silently.
  always_comb begin
    wr_ready   = 1'b1;
    sel_full   = 1'b0;
    sel_active = '0;
    wr_sel     = '0;
    req_sel    = '0;
    done_sel   = '0;
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      wr_sel[s]   = (wr.stage == TEX_DCR_STAGE_BITS_MAX'(s));
      req_sel[s]  = (bus.req_stage == STAGE_BITS'(s));
      done_sel[s] = bus.done_valid && (bus.done_stage == STAGE_BITS'(s));
      if (wr_sel[s]) begin
        wr_ready = !pending[s];
      end
      if (req_sel[s]) begin
        sel_full   = full[s];
        sel_active = active[s];
      end
    end
  end

  always_comb begin
    req_ready = (!rsp_valid_q || bus.rsp_ready) && !sel_full;
    wr_fire   = bus.dcr_wr_valid && wr_ready;
    req_fire  = bus.req_valid && req_ready;
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    tex_dcr_stage #(
      .INFLIGHT_BITS(INFLIGHT_BITS)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en_i  (wr_fire && wr_sel[s]),
      .wr_off_i (wr.offset),
      .wr_data_i(wr.data),
      .req_acc_i(req_fire && req_sel[s]),
      .done_i   (done_sel[s]),
      .active_o (active[s]),
      .pending_o(pending[s]),
      .full_o   (full[s])
    );
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_dcrs_d  = rsp_dcrs_q;
    if (req_fire) begin
      rsp_valid_d = 1'b1;
      rsp_dcrs_d  = sel_active;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_dcrs_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_dcrs_q  <= rsp_dcrs_d;
    end
  end

  assign bus.dcr_wr_ready = wr_ready;
  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_dcrs     = rsp_dcrs_q;
  assign pending_commit   = pending;

endmodule

// File: tb/tb_tex_dcr_bank.sv
// Bench for tex_dcr_bank: offset-map table, directed commit/backpressure/reset
// sequences and randomized traffic, all checked against a transaction model.
module tb_tex_dcr_bank;
  import tex_dcr_bank_pkg::*;

  localparam int NS   = 4;
  localparam int MAXC = 15;

  localparam int F_BASE = 0, F_LU = 1, F_LV = 2, F_WU = 3, F_WV = 4;
  localparam int F_FMT  = 5, F_FLT = 6, F_MIP0 = 7, F_MIP3 = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NS-1:0] pending_commit;

  always #5 clk = ~clk;

  tex_dcr_bank_if #(.NUM_STAGES(NS), .DATA_BITS(32)) bus ();

  tex_dcr_bank #(
    .NUM_STAGES   (NS),
    .INFLIGHT_BITS(4),
    .DATA_BITS    (32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .pending_commit(pending_commit)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model
  tex_dcrs_t m_shadow [NS];
  tex_dcrs_t m_active [NS];
  int        m_cnt    [NS];
  bit        m_pend   [NS];
  bit        m_rsp_valid;
  tex_dcrs_t m_rsp;
  bit        wr_stalled;

  typedef struct {
    int          stage;
    int          off;
    logic [31:0] data;
    int          field;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic tex_dcrs_t model_write(tex_dcrs_t cur, int off, logic [31:0] d);
    tex_dcrs_t r = cur;
    case (off)
      0: r.baseaddr = 26'(d);
      1: begin r.logdim_u = 4'(d); r.logdim_v = 4'(d >> 16); end
      2: begin r.wrap_u = 2'(d); r.wrap_v = 2'(d >> 16); end
      3: r.format = 3'(d);
      4: r.filter = 1'(d);
      6, 7, 8, 9: r.mipoff[off-6] = 16'(d);
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] get_field(tex_dcrs_t d, int f);
    case (f)
      F_BASE: return 32'(d.baseaddr);
      F_LU:   return 32'(d.logdim_u);
      F_LV:   return 32'(d.logdim_v);
      F_WU:   return 32'(d.wrap_u);
      F_WV:   return 32'(d.wrap_v);
      F_FMT:  return 32'(d.format);
      F_FLT:  return 32'(d.filter);
      F_MIP0: return 32'(d.mipoff[0]);
      default: return 32'(d.mipoff[3]);
    endcase
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_shadow[s] = '0; m_active[s] = '0; m_cnt[s] = 0; m_pend[s] = 0;
    end
    m_rsp_valid = 0; m_rsp = '0; wr_stalled = 0;
  endtask

  task automatic idle_inputs();
    bus.dcr_wr_valid = 0; bus.dcr_wr_stage = '0; bus.dcr_wr_offset = '0; bus.dcr_wr_data = '0;
    bus.req_valid = 0; bus.req_stage = '0; bus.rsp_ready = 1;
    bus.done_valid = 0; bus.done_stage = '0;
  endtask

  // One clock: check handshakes before the edge, advance model, check registers after.
  task automatic cycle();
    int ws, wo, rs, ds;
    bit wr_rdy, rq_rdy, wr_fire, rq_fire, rr, dv;
    logic [31:0] wd;
    logic [NS-1:0] ep;
    #1;
    ws = int'(bus.dcr_wr_stage); wo = int'(bus.dcr_wr_offset); wd = bus.dcr_wr_data;
    rs = int'(bus.req_stage); ds = int'(bus.done_stage);
    rr = bus.rsp_ready; dv = bus.done_valid;
    wr_rdy = (ws < NS) ? !m_pend[ws] : 1'b1;
    rq_rdy = (!m_rsp_valid || rr) && !((rs < NS) && (m_cnt[rs] == MAXC));
    chk("dcr_wr_ready", 128'(bus.dcr_wr_ready), 128'(wr_rdy));
    chk("req_ready", 128'(bus.req_ready), 128'(rq_rdy));
    wr_fire = bus.dcr_wr_valid && wr_rdy;
    rq_fire = bus.req_valid && rq_rdy;
    wr_stalled = bus.dcr_wr_valid && !wr_rdy;
    @(posedge clk);
    for (int s = 0; s < NS; s++) begin
      if (m_pend[s] && m_cnt[s] == 0 && !(rq_fire && rs == s)) begin
        m_active[s] = m_shadow[s];
        m_pend[s]   = 0;
      end
    end
    if (wr_fire && ws < NS) begin
      if (wo == 5) m_pend[ws] = 1;
      else m_shadow[ws] = model_write(m_shadow[ws], wo, wd);
    end
    if (rq_fire) begin
      m_rsp = (rs < NS) ? m_active[rs] : '0;
      m_rsp_valid = 1;
      if (rs < NS) m_cnt[rs]++;
    end else if (rr) begin
      m_rsp_valid = 0;
    end
    if (dv && ds < NS && m_cnt[ds] > 0) m_cnt[ds]--;
    #1;
    for (int s = 0; s < NS; s++) ep[s] = m_pend[s];
    chk("rsp_valid", 128'(bus.rsp_valid), 128'(m_rsp_valid));
    chk("rsp_dcrs", 128'(bus.rsp_dcrs), 128'(m_rsp));
    chk("pending_commit", 128'(pending_commit), 128'(ep));
  endtask

  task automatic wr(int s, int off, logic [31:0] d);
    bus.dcr_wr_valid = 1; bus.dcr_wr_stage = 2'(s); bus.dcr_wr_offset = tex_dcr_off_t'(off);
    bus.dcr_wr_data = d;
    cycle();
    bus.dcr_wr_valid = 0;
  endtask

  task automatic lookup(int s);
    bus.req_valid = 1; bus.req_stage = 2'(s);
    cycle();
    bus.req_valid = 0;
  endtask

  task automatic retire(int s);
    bus.done_valid = 1; bus.done_stage = 2'(s);
    cycle();
    bus.done_valid = 0;
  endtask

  task automatic idle(int n);
    repeat (n) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1, 0, 32'h0123_4567, F_BASE, 32'h0123_4567};
    tbl[1]  = '{1, 0, 32'hFFFF_FFFF, F_BASE, 32'h03FF_FFFF};
    tbl[2]  = '{1, 3, 32'h0000_0005, F_FMT,  32'h5};
    tbl[3]  = '{2, 1, 32'h000A_0005, F_LU,   32'h5};
    tbl[4]  = '{2, 1, 32'h000A_0005, F_LV,   32'hA};
    tbl[5]  = '{3, 2, 32'h0002_0003, F_WU,   32'h3};
    tbl[6]  = '{3, 2, 32'h0001_0002, F_WV,   32'h1};
    tbl[7]  = '{0, 4, 32'hFFFF_FFFE, F_FLT,  32'h0};
    tbl[8]  = '{0, 4, 32'h0000_0001, F_FLT,  32'h1};
    tbl[9]  = '{3, 6, 32'hABCD_1234, F_MIP0, 32'h1234};
    tbl[10] = '{3, 9, 32'h5555_BEEF, F_MIP3, 32'hBEEF};
    tbl[11] = '{3, 12, 32'hFFFF_FFFF, F_MIP3, 32'hBEEF};

    idle_inputs();
    model_reset();
    reset_n = 0;
    #3;
    chk("reset rsp_valid", 128'(bus.rsp_valid), 128'(0));
    chk("reset rsp_dcrs", 128'(bus.rsp_dcrs), 128'(0));
    chk("reset dcr_wr_ready", 128'(bus.dcr_wr_ready), 128'(1));
    chk("reset req_ready", 128'(bus.req_ready), 128'(1));
    chk("reset pending", 128'(pending_commit), 128'(0));
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;

    // Base address and format together, then commit and look up
    wr(1, 0, 32'h0123_4567);
    wr(1, 3, 32'h5);
    wr(1, 5, 32'h0);
    idle(1);
    lookup(1);
    chk("plan1 baseaddr", 128'(bus.rsp_dcrs.baseaddr), 128'(26'h123_4567));
    chk("plan1 format", 128'(bus.rsp_dcrs.format), 128'(5));
    retire(1);

    // Uncommitted shadow write must not be visible
    wr(0, 4, 32'h1);
    lookup(0);
    chk("shadow hidden filter", 128'(bus.rsp_dcrs.filter), 128'(0));
    retire(0);

    // Offset map table
    for (int i = 0; i < 12; i++) begin
      wr(tbl[i].stage, tbl[i].off, tbl[i].data);
      wr(tbl[i].stage, 5, 32'h0);
      idle(1);
      lookup(tbl[i].stage);
      chk($sformatf("table[%0d] field", i),
          128'(get_field(bus.rsp_dcrs, tbl[i].field)), 128'(tbl[i].exp));
      retire(tbl[i].stage);
    end

    // Commit deferred by three in-flight lookups on stage 2
    wr(2, 3, 32'h6);
    lookup(2); lookup(2); lookup(2);
    wr(2, 5, 32'h0);
    idle(2);
    chk("deferred pending", 128'(pending_commit[2]), 128'(1));
    bus.dcr_wr_stage = 2'd2; #1;
    chk("deferred wr_ready s2", 128'(bus.dcr_wr_ready), 128'(0));
    bus.dcr_wr_stage = 2'd1; #1;
    chk("deferred wr_ready s1", 128'(bus.dcr_wr_ready), 128'(1));
    retire(2); retire(2); retire(2);
    chk("pending after last done", 128'(pending_commit[2]), 128'(1));
    idle(1);
    chk("pending cleared", 128'(pending_commit[2]), 128'(0));
    lookup(2);
    chk("deferred format", 128'(bus.rsp_dcrs.format), 128'(6));
    retire(2);

    // Same-cycle increment and decrement on stage 3 with count 1
    lookup(3);
    wr(3, 4, 32'h1);
    wr(3, 5, 32'h0);
    bus.req_valid = 1; bus.req_stage = 2'd3; bus.done_valid = 1; bus.done_stage = 2'd3;
    cycle();
    bus.req_valid = 0; bus.done_valid = 0;
    idle(2);
    chk("inc/dec no commit", 128'(pending_commit[3]), 128'(1));
    retire(3);
    idle(1);
    chk("inc/dec commit later", 128'(pending_commit[3]), 128'(0));

    // Backpressure: response held while the consumer stalls
    bus.rsp_ready = 0;
    lookup(1);
    bus.req_valid = 1; bus.req_stage = 2'd2;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("bp req_ready", 128'(bus.req_ready), 128'(0));
      chk("bp rsp_dcrs stable", 128'(bus.rsp_dcrs), 128'(m_active[1]));
    end
    bus.req_valid = 0; bus.rsp_ready = 1;
    cycle();
    retire(1);

    // Saturation of stage 0 at the counter maximum
    bus.req_valid = 1; bus.req_stage = 2'd0;
    repeat (MAXC) cycle();
    bus.req_valid = 0; #1;
    chk("sat req_ready s0", 128'(bus.req_ready), 128'(0));
    bus.req_stage = 2'd1; #1;
    chk("sat req_ready s1", 128'(bus.req_ready), 128'(1));
    bus.req_valid = 1; bus.req_stage = 2'd0;
    cycle();
    bus.req_valid = 0;
    repeat (MAXC) retire(0);

    // Reset while a commit is pending and a response is held
    lookup(1);
    wr(1, 0, 32'h0000_00AA);
    wr(1, 5, 32'h0);
    bus.rsp_ready = 0;
    lookup(2);
    bus.dcr_wr_stage = 2'd1; bus.req_stage = 2'd1;
    #2;
    reset_n = 0;
    #1;
    chk("midreset rsp_valid", 128'(bus.rsp_valid), 128'(0));
    chk("midreset rsp_dcrs", 128'(bus.rsp_dcrs), 128'(0));
    chk("midreset pending", 128'(pending_commit), 128'(0));
    chk("midreset dcr_wr_ready", 128'(bus.dcr_wr_ready), 128'(1));
    chk("midreset req_ready", 128'(bus.req_ready), 128'(1));
    model_reset();
    idle_inputs();
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    wr(1, 5, 32'h0);
    idle(1);
    lookup(1);
    chk("shadow discarded", 128'(bus.rsp_dcrs), 128'(0));
    retire(1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int s;
      if (!wr_stalled) begin
        bus.dcr_wr_valid  = ($urandom_range(0, 2) == 0);
        bus.dcr_wr_stage  = 2'($urandom_range(0, NS - 1));
        bus.dcr_wr_offset = ($urandom_range(0, 3) == 0) ? tex_dcr_off_t'(5)
                                                        : tex_dcr_off_t'($urandom_range(0, 15));
        bus.dcr_wr_data   = $urandom;
      end
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_stage = 2'($urandom_range(0, NS - 1));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      s = $urandom_range(0, NS - 1);
      bus.done_stage = 2'(s);
      bus.done_valid = (m_cnt[s] > 0) && ($urandom_range(0, 1) == 1);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
